// File: rtl/pref_pkg.sv
// Shared prefetch address types used by the IP-stride prefetcher and the prefetch issue queue.
package pref_pkg;

    localparam int ADDR_SIZE       = 64;
    localparam int LOG2_BLOCK_SIZE = 6;
    localparam int LOG2_PAGE_SIZE  = 12;
    localparam int CLA_SIZE        = ADDR_SIZE - LOG2_BLOCK_SIZE;

    typedef logic [ADDR_SIZE-1:0] addr_t;
    typedef logic [CLA_SIZE-1:0]  cla_t;

    function automatic cla_t to_cla(addr_t a);
        return cla_t'(a >> LOG2_BLOCK_SIZE);
    endfunction

    function automatic addr_t to_addr(cla_t c);
        return {c, {LOG2_BLOCK_SIZE{1'b0}}};
    endfunction

    function automatic logic same_page(addr_t a, addr_t b);
        return (a >> LOG2_PAGE_SIZE) == (b >> LOG2_PAGE_SIZE);
    endfunction

endpackage

// File: rtl/pref_issue_queue_if.sv
// L2 prefetch request handshake between the issue queue (master) and the request arbiter (slave).
interface pref_issue_queue_if;
    import pref_pkg::*;

    addr_t req_addr_o;
    logic  req_valid_o;
    logic  req_ready_i;

    modport master (
        output req_addr_o,
        output req_valid_o,
        input  req_ready_i
    );

    modport slave (
        input  req_addr_o,
        input  req_valid_o,
        output req_ready_i
    );

endinterface

// File: rtl/pref_recent_filter.sv
// Small CAM of recently issued block addresses, refilled round-robin on every issue handshake.
module pref_recent_filter
    import pref_pkg::*;
#(
    parameter int FILTER_ENTRIES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  cla_t       lookup_cla [3],
    output logic [2:0] lookup_hit,
    input  logic       ins_valid,
    input  cla_t       ins_cla
);

    localparam int FW = (FILTER_ENTRIES > 1) ? $clog2(FILTER_ENTRIES) : 1;

    cla_t                    tag [FILTER_ENTRIES];
    logic [FILTER_ENTRIES-1:0] tag_vld;
    logic [FW-1:0]           ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            ptr     <= '0;
        end else if (ins_valid) begin
            tag_vld[ptr] <= 1'b1;
            ptr          <= (ptr == FW'(FILTER_ENTRIES - 1)) ? '0 : ptr + FW'(1);
        end
    end

    // Tag contents need no reset: tag_vld gates every match.
    always_ff @(posedge clk) begin
        if (ins_valid) begin
            tag[ptr] <= ins_cla;
        end
    end

    always_comb begin
        lookup_hit = '0;
        for (int k = 0; k < 3; k++) begin
            for (int e = 0; e < FILTER_ENTRIES; e++) begin
                if (tag_vld[e] && (tag[e] == lookup_cla[k])) begin
                    lookup_hit[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pref_issue_queue.sv
// Prefetch issue queue: dedups and buffers up to three candidates per cycle, issues one per handshake.
// Optional recently-issued filter is built when PREF_RECENT_FILTER_EN is defined.
module pref_issue_queue
    import pref_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 8,
    parameter int FILTER_ENTRIES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  addr_t                         pref_addr1_i,
    input  addr_t                         pref_addr2_i,
    input  addr_t                         pref_addr3_i,
    input  logic                          pref_valid1_i,
    input  logic                          pref_valid2_i,
    input  logic                          pref_valid3_i,
    pref_issue_queue_if.master            req,
    output logic [15:0]                   drop_full_o,
    output logic [15:0]                   drop_dup_o,
    output logic [$clog2(QUEUE_DEPTH):0]  occupancy_o
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    if ((QUEUE_DEPTH < 4) || (QUEUE_DEPTH > 32) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)
        || (FILTER_ENTRIES < 2)) begin : g_bad_param
        $error("pref_issue_queue: unsupported QUEUE_DEPTH or FILTER_ENTRIES");
    end

    function automatic logic [15:0] sat_add(logic [15:0] cnt, logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    cla_t              mem [QUEUE_DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [15:0]       drop_full;
    logic [15:0]       drop_dup;

    logic              req_valid;
    logic              pop;
    logic [CW-1:0]     free_slots;
    logic [QUEUE_DEPTH-1:0] ent_vld;

    cla_t              cand_cla [3];
    logic [2:0]        cand_vld;
    logic [2:0]        filt_hit;
    logic [2:0]        dup;
    logic [2:0]        acc;
    logic [PW-1:0]     wr_idx [3];
    logic [1:0]        n_acc;
    logic [1:0]        n_dup;
    logic [1:0]        n_full;

    assign cand_cla[0] = to_cla(pref_addr1_i);
    assign cand_cla[1] = to_cla(pref_addr2_i);
    assign cand_cla[2] = to_cla(pref_addr3_i);
    assign cand_vld    = {pref_valid3_i, pref_valid2_i, pref_valid1_i};

    assign req_valid  = (count != '0);
    assign pop        = req_valid && req.req_ready_i;
    assign free_slots = CW'(QUEUE_DEPTH) - count + CW'(pop);

`ifdef PREF_RECENT_FILTER_EN
    pref_recent_filter #(
        .FILTER_ENTRIES (FILTER_ENTRIES)
    ) u_recent_filter (
        .clk        (clk),
        .rst        (rst),
        .lookup_cla (cand_cla),
        .lookup_hit (filt_hit),
        .ins_valid  (pop),
        .ins_cla    (mem[head])
    );
`else
    assign filt_hit = '0;
`endif

    // Entry i is live when its distance from head is below count; the popped head still counts.
    always_comb begin
        ent_vld = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            ent_vld[i] = ({1'b0, PW'(i) - head} < count);
        end
    end

    always_comb begin
        dup    = '0;
        acc    = '0;
        n_acc  = '0;
        n_dup  = '0;
        n_full = '0;
        for (int k = 0; k < 3; k++) begin
            wr_idx[k] = '0;
        end
        for (int k = 0; k < 3; k++) begin
            if (cand_vld[k]) begin
                dup[k] = filt_hit[k];
                for (int i = 0; i < QUEUE_DEPTH; i++) begin
                    if (ent_vld[i] && (mem[i] == cand_cla[k])) begin
                        dup[k] = 1'b1;
                    end
                end
                for (int j = 0; j < k; j++) begin
                    if (acc[j] && (cand_cla[j] == cand_cla[k])) begin
                        dup[k] = 1'b1;
                    end
                end
                if (dup[k]) begin
                    n_dup = n_dup + 2'd1;
                end else if (CW'(n_acc) < free_slots) begin
                    acc[k]    = 1'b1;
                    wr_idx[k] = tail + PW'(n_acc);
                    n_acc     = n_acc + 2'd1;
                end else begin
                    n_full = n_full + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            drop_full <= '0;
            drop_dup  <= '0;
        end else begin
            head      <= head + PW'(pop);
            tail      <= tail + PW'(n_acc);
            count     <= count - CW'(pop) + CW'(n_acc);
            drop_full <= sat_add(drop_full, n_full);
            drop_dup  <= sat_add(drop_dup, n_dup);
        end
    end

    // Storage is data only; writes always land in free slots so the head entry stays stable.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (acc[k]) begin
                mem[wr_idx[k]] <= cand_cla[k];
            end
        end
    end

    assign req.req_valid_o = req_valid;
    assign req.req_addr_o  = req_valid ? to_addr(mem[head]) : '0;
    assign drop_full_o     = drop_full;
    assign drop_dup_o      = drop_dup;
    assign occupancy_o     = count;

endmodule

// File: tb/tb_pref_issue_queue.sv
// Bench for pref_issue_queue: test-plan vector table plus scoreboard model of queue, dedup and counters.
module tb_pref_issue_queue;
    import pref_pkg::*;

    localparam int DEPTH = 8;
    localparam int FE    = 16;
`ifdef PREF_RECENT_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    addr_t       a1, a2, a3;
    logic        v1, v2, v3;
    logic [15:0] drop_full, drop_dup;
    logic [3:0]  occ;

    pref_issue_queue_if rq();

    pref_issue_queue #(
        .QUEUE_DEPTH    (DEPTH),
        .FILTER_ENTRIES (FE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pref_addr1_i  (a1),
        .pref_addr2_i  (a2),
        .pref_addr3_i  (a3),
        .pref_valid1_i (v1),
        .pref_valid2_i (v2),
        .pref_valid3_i (v3),
        .req           (rq),
        .drop_full_o   (drop_full),
        .drop_dup_o    (drop_dup),
        .occupancy_o   (occ)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Scoreboard: expected issue order, recently issued blocks, expected counters.
    addr_t sb[$];
    addr_t recent[$];
    int    m_full;
    int    m_dup;

    typedef struct {
        logic [2:0] v;
        addr_t      a1, a2, a3;
        logic       rdy;
        logic       exp_valid;
        addr_t      exp_addr;
        int         exp_occ;
        int         exp_full;
        int         exp_dup;
    } vec_t;

    vec_t vec [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_step(input logic [2:0] v, input addr_t c1, input addr_t c2,
                              input addr_t c3, input logic rdy, input logic r);
        addr_t blk [3];
        addr_t acc_q[$];
        addr_t x;
        bit    pop;
        bit    is_dup;
        int    free;
        if (r) begin
            sb.delete();
            recent.delete();
            m_full = 0;
            m_dup  = 0;
            return;
        end
        blk[0] = c1 & ~64'h3f;
        blk[1] = c2 & ~64'h3f;
        blk[2] = c3 & ~64'h3f;
        pop  = (sb.size() != 0) && rdy;
        free = DEPTH - sb.size() + (pop ? 1 : 0);
        for (int k = 0; k < 3; k++) begin
            if (v[k]) begin
                is_dup = 1'b0;
                foreach (sb[i])     if (sb[i] == blk[k])     is_dup = 1'b1;
                foreach (acc_q[i])  if (acc_q[i] == blk[k])  is_dup = 1'b1;
                if (FILT) foreach (recent[i]) if (recent[i] == blk[k]) is_dup = 1'b1;
                if (is_dup)                     m_dup  = (m_dup  < 65535) ? m_dup + 1  : 65535;
                else if (acc_q.size() < free)   acc_q.push_back(blk[k]);
                else                            m_full = (m_full < 65535) ? m_full + 1 : 65535;
            end
        end
        if (pop) begin
            x = sb.pop_front();
            recent.push_back(x);
            if (recent.size() > FE) void'(recent.pop_front());
        end
        foreach (acc_q[i]) sb.push_back(acc_q[i]);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, 64'(rq.req_valid_o), 64'(sb.size() != 0));
        if (sb.size() != 0) chk({tag, "_addr"}, rq.req_addr_o, sb[0]);
        chk({tag, "_occ"},  64'(occ),       64'(sb.size()));
        chk({tag, "_full"}, 64'(drop_full), 64'(m_full));
        chk({tag, "_dup"},  64'(drop_dup),  64'(m_dup));
    endtask

    task automatic cycle(input string tag, input logic [2:0] v, input addr_t c1, input addr_t c2,
                         input addr_t c3, input logic rdy, input logic r);
        v1 = v[0]; v2 = v[1]; v3 = v[2];
        a1 = c1;   a2 = c2;   a3 = c3;
        rq.req_ready_i = rdy;
        rst = r;
        @(posedge clk);
        model_step(v, c1, c2, c3, rdy, r);
        @(negedge clk);
        rst = 1'b0;
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        rq.req_ready_i = 1'b0;
        check_model(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        d = FILT ? 2 : 1;
        vec[0]  = '{3'b001, 64'h1000, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1000, 1, 0, 0};
        vec[1]  = '{3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1000, 1, 0, 0};
        vec[2]  = '{3'b000, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 0, 0, 0};
        vec[3]  = '{3'b111, 64'h2040, 64'h2041, 64'h2080, 1'b0, 1'b1, 64'h2040, 2, 0, 1};
        vec[4]  = '{3'b000, 64'h0, 64'h0, 64'h0, 1'b1, 1'b1, 64'h2080, 1, 0, 1};
        vec[5]  = '{3'b000, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 0, 0, 1};
        vec[6]  = '{3'b001, 64'h3000, 64'h0, 64'h0, 1'b0, 1'b1, 64'h3000, 1, 0, 1};
        vec[7]  = '{3'b000, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 0, 0, 1};
        if (FILT) vec[8] = '{3'b001, 64'h3000, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 0, 0, 2};
        else      vec[8] = '{3'b001, 64'h3000, 64'h0, 64'h0, 1'b0, 1'b1, 64'h3000, 1, 0, 1};
        vec[9]  = '{3'b000, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 0, 0, d};
        vec[10] = '{3'b111, 64'h4000, 64'h4040, 64'h4080, 1'b0, 1'b1, 64'h4000, 3, 0, d};
        vec[11] = '{3'b111, 64'h40c0, 64'h4100, 64'h4140, 1'b0, 1'b1, 64'h4000, 6, 0, d};
        vec[12] = '{3'b001, 64'h4180, 64'h0, 64'h0, 1'b0, 1'b1, 64'h4000, 7, 0, d};
        vec[13] = '{3'b111, 64'h5000, 64'h5040, 64'h5080, 1'b0, 1'b1, 64'h4000, 8, 2, d};
        vec[14] = '{3'b111, 64'h6000, 64'h6040, 64'h6080, 1'b1, 1'b1, 64'h4040, 8, 4, d};
        vec[15] = '{3'b001, 64'h4040, 64'h0, 64'h0, 1'b1, 1'b1, 64'h4080, 7, 4, d + 1};

        rst = 1'b1;
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        a1 = '0; a2 = '0; a3 = '0;
        rq.req_ready_i = 1'b0;
        m_full = 0;
        m_dup  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_valid", 64'(rq.req_valid_o), 64'h0);
        chk("reset_addr",  rq.req_addr_o,       64'h0);
        chk("reset_occ",   64'(occ),            64'h0);
        chk("reset_full",  64'(drop_full),      64'h0);
        chk("reset_dup",   64'(drop_dup),       64'h0);

        for (int r = 0; r < 16; r++) begin
            cycle($sformatf("vec%0d_model", r), vec[r].v, vec[r].a1, vec[r].a2, vec[r].a3,
                  vec[r].rdy, 1'b0);
            chk($sformatf("vec%0d_valid", r), 64'(rq.req_valid_o), 64'(vec[r].exp_valid));
            if (vec[r].exp_valid) chk($sformatf("vec%0d_addr", r), rq.req_addr_o, vec[r].exp_addr);
            chk($sformatf("vec%0d_occ", r),  64'(occ),       64'(vec[r].exp_occ));
            chk($sformatf("vec%0d_full", r), 64'(drop_full), 64'(vec[r].exp_full));
            chk($sformatf("vec%0d_dup", r),  64'(drop_dup),  64'(vec[r].exp_dup));
        end

        for (int n = 0; n < 20 && sb.size() != 0; n++)
            cycle("drain1", 3'b000, '0, '0, '0, 1'b1, 1'b0);
        chk("drain1_empty", 64'(occ), 64'h0);

        // Mid-operation reset with candidates and ready asserted in the reset cycle.
        cycle("fill_a", 3'b111, 64'h9000, 64'h9040, 64'h9080, 1'b0, 1'b0);
        cycle("fill_b", 3'b011, 64'h90c0, 64'h9100, 64'h0, 1'b0, 1'b0);
        chk("fill_occ5", 64'(occ), 64'h5);
        cycle("rst_mid", 3'b111, 64'ha000, 64'ha040, 64'ha080, 1'b1, 1'b1);
        chk("rst_mid_valid", 64'(rq.req_valid_o), 64'h0);
        chk("rst_mid_addr",  rq.req_addr_o,       64'h0);
        chk("rst_mid_occ",   64'(occ),            64'h0);
        chk("rst_mid_full",  64'(drop_full),      64'h0);
        chk("rst_mid_dup",   64'(drop_dup),       64'h0);
        cycle("post_rst", 3'b001, 64'h7000, 64'h0, 64'h0, 1'b0, 1'b0);
        chk("post_rst_valid", 64'(rq.req_valid_o), 64'h1);
        chk("post_rst_addr",  rq.req_addr_o,       64'h7000);
        chk("post_rst_occ",   64'(occ),            64'h1);

        for (int n = 0; n < 300; n++) begin
            addr_t r1, r2, r3;
            r1 = 64'h8000 + 64'($urandom_range(0, 11)) * 64 + 64'($urandom_range(0, 63));
            r2 = 64'h8000 + 64'($urandom_range(0, 11)) * 64 + 64'($urandom_range(0, 63));
            r3 = 64'h8000 + 64'($urandom_range(0, 11)) * 64 + 64'($urandom_range(0, 63));
            cycle("rand", 3'($urandom_range(0, 7)), r1, r2, r3, 1'($urandom_range(0, 1)), 1'b0);
        end

        for (int n = 0; n < 20 && sb.size() != 0; n++)
            cycle("drain2", 3'b000, '0, '0, '0, 1'b1, 1'b0);
        chk("drain2_empty", 64'(occ), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
